// File: rtl/serial_addsub_ctrl_pkg.sv
// ============================================================================
// Module  : serial_addsub_ctrl_pkg
// Brief   : Shared state encodings, slice width and op codes for serial_addsub_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_addsub_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_addsub_ctrl_nibble_addsub.sv
// ============================================================================
// Module  : nibble_addsub (+ full_adder)
// Brief   : Combinational 4-bit ripple add/sub slice; B inverted when sub=1.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module nibble_addsub
  import serial_addsub_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                sub,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);
  logic [NIBBLE_W-1:0] w_beff;
  logic [NIBBLE_W:0]   w_c;

  assign w_beff = sub ? ~b : b;
  assign w_c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    full_adder u_fa (
      .a   (a[i]),
      .b   (w_beff[i]),
      .cin (w_c[i]),
      .sum (sum[i]),
      .cout(w_c[i+1])
    );
  end

  assign cout = w_c[NIBBLE_W];
endmodule

`default_nettype wire

// File: rtl/serial_addsub_ctrl.sv
// ============================================================================
// Module  : serial_addsub_ctrl
// Brief   : Nibble-serial adder/subtractor, one shared 4-bit slice, LSB first.
//           Optional signed-overflow output enabled by SERIAL_ADDSUB_OVF_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_addsub_ctrl
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    op,
  input  logic [4*NIBBLES-1:0]    A,
  input  logic [4*NIBBLES-1:0]    B,
  output logic                    busy,
  output logic                    done,
  output logic [4*NIBBLES-1:0]    result,
  output logic                    carryout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic                    ovf
`endif
);
  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NIBBLES - 1);

  state_t              r_state;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic                r_op;
  logic [IDX_W-1:0]    r_idx;
  logic                r_cy;
  logic                r_busy;
  logic                r_done;
  logic [W-1:0]        r_result;
  logic                r_cout;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_sum;
  logic                w_cout;
  logic                w_last;

  assign w_a_nib = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
  assign w_b_nib = r_b[r_idx*NIBBLE_W +: NIBBLE_W];
  assign w_last  = (r_idx == C_LAST);

  nibble_addsub u_slice (
    .a   (w_a_nib),
    .b   (w_b_nib),
    .sub (r_op),
    .cin (r_cy),
    .sum (w_sum),
    .cout(w_cout)
  );

`ifdef SERIAL_ADDSUB_OVF_EN
  logic r_ovf;
  logic w_ovf;
  // Operand signs agree but the result sign differs from them.
  assign w_ovf = (r_a[W-1] == (r_b[W-1] ^ r_op)) && (w_sum[NIBBLE_W-1] != r_a[W-1]);
  assign ovf   = r_ovf;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_idx    <= '0;
      r_cy     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a    <= A;
            r_b    <= B;
            r_op   <= op;
            r_idx  <= '0;
            r_cy   <= op;  // +1 completes the two's complement of B on subtract
            r_busy <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_result[r_idx*NIBBLE_W +: NIBBLE_W] <= w_sum;
          r_cy <= w_cout;
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cout  <= w_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
            r_ovf   <= w_ovf;
`endif
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign carryout = r_cout;
endmodule

`default_nettype wire

// File: tb/tb_serial_addsub_ctrl.sv
// ============================================================================
// Module  : tb_serial_addsub_ctrl
// Brief   : Directed self-checking bench for serial_addsub_ctrl (NIBBLES=4).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_addsub_ctrl;
  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carryout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic        ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  serial_addsub_ctrl #(.NIBBLES(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .carryout(carryout)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One operation: pulse start, wait (bounded) for done, check latency and outputs.
  task automatic run_op(input string tag, input logic o, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_r,
                        input logic exp_c, input logic exp_v);
    int cyc;
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = ~a; B = ~b; op = ~o;  // changes after acceptance must not matter
    check({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'd4);
    check({tag, "_res"}, 32'(result), 32'(exp_r));
    check({tag, "_cout"}, 32'(carryout), 32'(exp_c));
`ifdef SERIAL_ADDSUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_v));
`else
    if (exp_v === 1'bx) $display("note: %s", tag);
`endif
    @(posedge clk); #1;
    check({tag, "_donepulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(result), 32'(exp_r));
  endtask

  initial begin
    int pulses;
    int first_at;
    int second_at;
    logic [15:0] seen;

    reset = 1'b1; start = 1'b1; op = 1'b0; A = 16'h1234; B = 16'h1111;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", 32'(result), 32'd0);
    check("rst_cout", 32'(carryout), 32'd0);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);

    run_op("add1", 1'b0, 16'h1234, 16'h0FED, 16'h2221, 1'b0, 1'b0);
    run_op("sub1", 1'b1, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0);
    run_op("sub2", 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
    run_op("addwrap", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    run_op("subeq", 1'b1, 16'h5555, 16'h5555, 16'h0000, 1'b1, 1'b0);
    run_op("addovf", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    run_op("subovf", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);

    // start pulsed during RUN with new operands must be ignored
    op = 1'b0; A = 16'h0001; B = 16'h0002; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; seen = 16'h0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin pulses++; seen = result; end
      @(posedge clk); #1;
    end
    check("ign_pulses", 32'(pulses), 32'd1);
    check("ign_res", 32'(seen), 32'h0003);

    // reset during the third RUN cycle aborts the operation
    op = 1'b0; A = 16'h1111; B = 16'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_res", 32'(result), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    run_op("post_rst", 1'b0, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 1'b0);

    // start held high: back-to-back operations, done pulses 5 cycles apart
    op = 1'b0; A = 16'h0001; B = 16'h0001; start = 1'b1;
    pulses = 0; first_at = -1; second_at = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (first_at < 0) begin
          first_at = i;
          check("b2b_res1", 32'(result), 32'h0002);
          A = 16'h0002; B = 16'h0003;
        end else begin
          second_at = i;
          check("b2b_res2", 32'(result), 32'h0005);
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_pulses", 32'(pulses), 32'd2);
    check("b2b_first", 32'(first_at), 32'd4);
    check("b2b_gap", 32'(second_at - first_at), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4, sets the number of 4-bit slices per operand (operand width = 4*NIBBLES).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-005 op  input  1  0 = add (A+B), 1 = subtract (A-B); sampled with start.
REQ-006 A  input  4*NIBBLES  minuend/addend; sampled with start.
REQ-007 B  input  4*NIBBLES  subtrahend/addend; sampled with start.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  one-cycle pulse when result is complete.
REQ-010 result  output  4*NIBBLES  sum/difference; stable from done until the next accepted start.
REQ-011 carryout  output  1  carry out of the top nibble; for subtract, 1 = no borrow (A >= B unsigned).
REQ-012 ovf  output  1  signed overflow flag; present only under SERIAL_ADDSUB_OVF_EN.

Function
REQ-013 Block sequences one shared 4-bit add/sub slice over NIBBLES cycles, LSB nibble first, chaining the carry through a carry register.
REQ-014 FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after nibble NIBBLES-1, DONE->RUN on start, otherwise DONE->IDLE.
REQ-015 On accepted start: latch A, B and op; clear the nibble index to 0; load the carry register with op (0 for add, 1 for subtract).
REQ-016 Each RUN cycle: slice inputs are A nibble[idx], B nibble[idx] (bitwise inverted when op=1) and the carry register.
REQ-017 Each RUN cycle: write the slice sum to result nibble[idx], write the slice carry to the carry register, and increment idx.
REQ-018 Latency: start sampled at edge k; nibbles processed at edges k+1..k+NIBBLES; done=1 during the cycle after edge k+NIBBLES.
REQ-019 carryout equals the carry register value after the last nibble; it updates together with done and holds thereafter.
REQ-020 start while busy=1 is ignored; the latched operands are unaffected.
REQ-021 start in DONE is accepted (back-to-back operation): done still pulses for one cycle and result begins updating on the next edge.
REQ-022 Input A/B/op changes after acceptance have no effect on the operation in progress.
REQ-023 idx wraps to 0 only through a new accepted start; it never exceeds NIBBLES-1 in RUN.

Reset
REQ-024 reset=1 at any edge forces IDLE, busy=0, done=0, result=0, carryout=0, ovf=0, idx=0, carry register=0, aborting any operation in progress.
REQ-025 start asserted in the same cycle as reset is ignored.

Configuration
REQ-026 With SERIAL_ADDSUB_OVF_EN defined, ovf = (A[msb]==Beff[msb]) && (result[msb]!=A[msb]), where Beff is B inverted for subtract; ovf is registered with done and holds until the next accepted start.
REQ-027 Without SERIAL_ADDSUB_OVF_EN, the ovf port and its logic are absent; all other behaviour is identical.

Structure
REQ-028 Shared package holds the state encodings (IDLE/RUN/DONE), the NIBBLE_W=4 constant and the op encodings (OP_ADD=0, OP_SUB=1).
REQ-029 One sub-module, nibble_addsub: a combinational 4-bit ripple adder with conditional B inversion, built from full-adder instances; it is instantiated once.

Verification
REQ-030 op=0, A=0x1234, B=0x0FED -> done 5 cycles after start, result=0x2221, carryout=0.
REQ-031 op=1, A=0x1000, B=0x0001 -> result=0x0FFF, carryout=1; op=1, A=0x0000, B=0x0001 -> result=0xFFFF, carryout=0.
REQ-032 With the macro defined: op=0, A=0x7FFF, B=0x0001 -> result=0x8000, ovf=1; op=1, A=0x8000, B=0x0001 -> result=0x7FFF, ovf=1.
REQ-033 start pulsed during RUN with A=0xFFFF -> ignored; the original result completes and done pulses exactly once.
REQ-034 reset asserted in the third RUN cycle -> next cycle busy=0, result=0, done=0; a new start then completes normally.
REQ-035 start held high through DONE -> back-to-back operations with one done pulse each, 5 cycles apart.
